// File: rtl/qpram_wr_arb.sv
// ---------------------------------------------------------------------------
// qpram_wr_arb
//
// Write-port arbiter for a 64x1 quad-port RAM. After reset (or a flush) the
// block sweeps every address with INIT_VAL, then arbitrates between two
// write requesters with a zero-latency, round-robin grant.
//
// Ports
//   CLK          clock, all state changes on the rising edge
//   RST_N        asynchronous active-low reset
//   flush_req    level request to re-run the init sweep (ignored if !FLUSH_EN)
//   reqN_valid   requester N has a write pending (N = 0, 1)
//   reqN_addr    requester N write address
//   reqN_data    requester N write data
//   reqN_ready   requester N write accepted this cycle (combinational)
//   ram_wen      RAM write enable
//   ram_aw       RAM write address
//   ram_di       RAM write data
//   init_done    RAM contents valid (arbiter in RUN)
// ---------------------------------------------------------------------------
module qpram_wr_arb #(
  parameter bit INIT_VAL = 1'b0,
  parameter bit FLUSH_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       flush_req,
  input  logic       req0_valid,
  input  logic [5:0] req0_addr,
  input  logic       req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [5:0] req1_addr,
  input  logic       req1_data,
  output logic       req1_ready,
  output logic       ram_wen,
  output logic [5:0] ram_aw,
  output logic       ram_di,
  output logic       init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [5:0] cnt_reg, cnt_next;
  logic       rr_reg, rr_next;

  logic       flush_act;
  logic       run_ok;
  logic [1:0] valid_vec;
  logic [1:0] gnt;
  logic       wen_int;

  assign flush_act = FLUSH_EN && flush_req;
  // A flush in RUN suppresses all grants in the cycle it is seen.
  assign run_ok    = (state_reg == ST_RUN) && !flush_act;
  assign valid_vec = {req1_valid, req0_valid};

  // Requester gi wins when it is valid and either alone or holding the
  // round-robin token.
  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    localparam logic IDX = 1'(gi);
    assign gnt[gi] = run_ok && valid_vec[gi] &&
                     (!valid_vec[1-gi] || (rr_reg == IDX));
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_INIT;
      cnt_reg   <= 6'd0;
      rr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rr_reg    <= rr_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rr_next    = rr_reg;
    unique case (state_reg)
      ST_INIT: begin
        if (flush_act) begin
          cnt_next = 6'd0;
        end else begin
          // 6-bit wrap takes cnt back to 0 on the final sweep write.
          cnt_next = cnt_reg + 6'd1;
          if (cnt_reg == 6'd63) begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (flush_act) begin
          state_next = ST_INIT;
          cnt_next   = 6'd0;
        end else if (&valid_vec) begin
          // Token passes to whichever requester lost this cycle.
          rr_next = ~rr_reg;
        end
      end
      default: begin
        state_next = ST_INIT;
        cnt_next   = 6'd0;
      end
    endcase
  end

  // RAM write port mux. Idle cycles drive zeros so the port never carries X.
  always_comb begin
    wen_int = 1'b0;
    ram_aw  = 6'd0;
    ram_di  = 1'b0;
    if (state_reg == ST_INIT) begin
      wen_int = 1'b1;
      ram_aw  = cnt_reg;
      ram_di  = INIT_VAL;
    end else if (gnt[1]) begin
      wen_int = 1'b1;
      ram_aw  = req1_addr;
      ram_di  = req1_data;
    end else if (gnt[0]) begin
      wen_int = 1'b1;
      ram_aw  = req0_addr;
      ram_di  = req0_data;
    end
  end

  // The sweep drives a write from INIT, which is also the reset state, so the
  // enable is masked by RST_N to keep the RAM untouched while reset is held.
  assign ram_wen    = wen_int && RST_N;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign init_done  = (state_reg == ST_RUN);

endmodule

// File: tb/tb_qpram_wr_arb.sv
module tb_qpram_wr_arb;

  localparam bit INIT_VAL = 1'b0;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       flush_req;
  logic       req0_valid, req1_valid;
  logic [5:0] req0_addr, req1_addr;
  logic       req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       ram_wen;
  logic [5:0] ram_aw;
  logic       ram_di;
  logic       init_done;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  qpram_wr_arb #(.INIT_VAL(INIT_VAL), .FLUSH_EN(1'b1)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .flush_req (flush_req),
    .req0_valid(req0_valid),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .ram_wen   (ram_wen),
    .ram_aw    (ram_aw),
    .ram_di    (ram_di),
    .init_done (init_done)
  );

  // External 64x1 RAM with asynchronous read, written by the DUT port.
  logic tb_ram [64];
  always @(posedge CLK) begin
    if (ram_wen === 1'b1) tb_ram[ram_aw] <= ram_di;
  end

  // ---------------------------------------------------------------------
  // Reference model: sweeping flag, sweep position, whose turn it is when
  // both ask, and the expected RAM contents.
  // ---------------------------------------------------------------------
  bit m_run;
  int m_idx;
  int m_turn;
  bit m_mem [64];

  function automatic logic [10:0] obs_vec();
    return {req0_ready, req1_ready, ram_wen, ram_aw, ram_di, init_done};
  endfunction

  // Expected {ready0, ready1, wen, aw, di, done} for the current inputs;
  // g is the granted requester or -1.
  function automatic logic [10:0] model_vec(output int g);
    logic       r0, r1, wen, di;
    logic [5:0] aw;
    g = -1; r0 = 0; r1 = 0; wen = 0; di = 0; aw = 0;
    if (!m_run) begin
      wen = 1; aw = 6'(m_idx); di = INIT_VAL;
    end else if (!flush_req) begin
      if (req0_valid && req1_valid) g = m_turn;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
      if (g == 0) begin r0 = 1; wen = 1; aw = req0_addr; di = req0_data; end
      if (g == 1) begin r1 = 1; wen = 1; aw = req1_addr; di = req1_data; end
    end
    return {r0, r1, wen, aw, di, m_run};
  endfunction

  task automatic model_advance();
    int g;
    void'(model_vec(g));
    if (!RST_N) begin
      m_run = 0; m_idx = 0; m_turn = 0;
      return;
    end
    if (!m_run) begin
      m_mem[m_idx] = INIT_VAL;
      if (flush_req)          m_idx = 0;
      else if (m_idx == 63) begin m_run = 1; m_idx = 0; end
      else                    m_idx = m_idx + 1;
    end else if (flush_req) begin
      m_run = 0; m_idx = 0;
    end else begin
      if (g == 0) m_mem[req0_addr] = req0_data;
      if (g == 1) m_mem[req1_addr] = req1_data;
      if (req0_valid && req1_valid) m_turn = 1 - g;
    end
  endtask

  // Advance one clock edge; inputs may be changed once this returns.
  task automatic tick();
    @(posedge CLK);
    model_advance();
    #1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    req0_valid = 1; req0_addr = 6'd5; req0_data = 1'b1;
    req1_valid = 1; req1_addr = 6'd9; req1_data = 1'b0;
    #2;
    checks++;
    if ({req0_ready, req1_ready, ram_wen, init_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {req0_ready, req1_ready, ram_wen, init_done});
    end
    @(posedge CLK); #1;
    checks++;
    if ({req0_ready, req1_ready, ram_wen, init_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held_edge: got %b expected 0000",
               {req0_ready, req1_ready, ram_wen, init_done});
    end
    RST_N = 1'b1;
    m_run = 0; m_idx = 0; m_turn = 0;
    $display("reset released");
  endtask

  task automatic test_init_sweep();
    logic [10:0] e;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      e = {1'b0, 1'b0, 1'b1, 6'(i), INIT_VAL, 1'b0};
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL init_sweep[%0d]: got %b expected %b", i, obs_vec(), e);
      end
      tick();
    end
    @(negedge CLK);
    e = {1'b1, 1'b0, 1'b1, 6'd5, 1'b1, 1'b1};
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL first_grant_req0: got %b expected %b", obs_vec(), e);
    end
    tick();
    @(negedge CLK);
    e = {1'b0, 1'b1, 1'b1, 6'd9, 1'b0, 1'b1};
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL second_grant_req1: got %b expected %b", obs_vec(), e);
    end
    tick();
    $display("init sweep: 64 writes then grants req0, req1");
  endtask

  task automatic test_alternate();
    logic [10:0] e;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      e = (k % 2 == 0) ? {1'b1, 1'b0, 1'b1, 6'd5, 1'b1, 1'b1}
                       : {1'b0, 1'b1, 1'b1, 6'd9, 1'b0, 1'b1};
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL alternate[%0d]: got %b expected %b", k, obs_vec(), e);
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge CLK);
    e = {1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1};
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL idle_run: got %b expected %b", obs_vec(), e);
    end
    tick();
    $display("alternate: aw 5,9,5,9 then idle");
  endtask

  task automatic test_single();
    logic [10:0] e;
    req0_valid = 1; req0_addr = 6'd63; req0_data = 1'b1;
    @(negedge CLK);
    e = {1'b1, 1'b0, 1'b1, 6'd63, 1'b1, 1'b1};
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL single_req0: got %b expected %b", obs_vec(), e);
    end
    checks++;
    if (tb_ram[63] !== INIT_VAL) begin
      errors++;
      $display("FAIL single_old_read: got %b expected %b", tb_ram[63], INIT_VAL);
    end
    tick();
    req0_valid = 0;
    @(negedge CLK);
    checks++;
    if (tb_ram[63] !== 1'b1) begin
      errors++;
      $display("FAIL single_new_read: got %b expected 1", tb_ram[63]);
    end
    tick();
    $display("single: req0 wrote 1 to addr 63");
  endtask

  task automatic test_collision();
    logic [10:0] e;
    req0_valid = 1; req0_addr = 6'd12; req0_data = 1'b1;
    req1_valid = 1; req1_addr = 6'd12; req1_data = 1'b0;
    @(negedge CLK);
    e = {1'b1, 1'b0, 1'b1, 6'd12, 1'b1, 1'b1};
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL collide_first: got %b expected %b", obs_vec(), e);
    end
    tick();
    req0_valid = 0;
    @(negedge CLK);
    e = {1'b0, 1'b1, 1'b1, 6'd12, 1'b0, 1'b1};
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL collide_second: got %b expected %b", obs_vec(), e);
    end
    checks++;
    if (tb_ram[12] !== 1'b1) begin
      errors++;
      $display("FAIL collide_mid_read: got %b expected 1", tb_ram[12]);
    end
    tick();
    req1_valid = 0;
    @(negedge CLK);
    checks++;
    if (tb_ram[12] !== 1'b0) begin
      errors++;
      $display("FAIL collide_final_read: got %b expected 0", tb_ram[12]);
    end
    tick();
    $display("collision: addr 12 ends 0");
  endtask

  task automatic test_flush();
    logic [10:0] e;
    req1_valid = 1; req1_addr = 6'd20; req1_data = 1'b1;
    flush_req = 1;
    @(negedge CLK);
    e = {1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1};
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL flush_cycle: got %b expected %b", obs_vec(), e);
    end
    tick();
    flush_req = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      e = {1'b0, 1'b0, 1'b1, 6'(i), INIT_VAL, 1'b0};
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL flush_sweep[%0d]: got %b expected %b", i, obs_vec(), e);
      end
      tick();
    end
    @(negedge CLK);
    e = {1'b0, 1'b1, 1'b1, 6'd20, 1'b1, 1'b1};
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL flush_then_grant: got %b expected %b", obs_vec(), e);
    end
    tick();
    req1_valid = 0;
    $display("flush: sweep of 64 then req1 granted");
  endtask

  task automatic test_reset_mid_sweep();
    logic [10:0] e;
    flush_req = 1;
    tick();
    flush_req = 0;
    for (int i = 0; i < 30; i++) tick();
    @(negedge CLK);
    e = {1'b0, 1'b0, 1'b1, 6'd30, INIT_VAL, 1'b0};
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL sweep_at_30: got %b expected %b", obs_vec(), e);
    end
    req0_valid = 1; req0_addr = 6'd7; req0_data = 1'b1;
    RST_N = 0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, ram_wen, init_done} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_drop: got %b expected 0000",
               {req0_ready, req1_ready, ram_wen, init_done});
    end
    tick();
    RST_N = 1;
    req0_valid = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      e = {1'b0, 1'b0, 1'b1, 6'(i), INIT_VAL, 1'b0};
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL resweep[%0d]: got %b expected %b", i, obs_vec(), e);
      end
      tick();
    end
    @(negedge CLK);
    e = {1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1};
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL resweep_done: got %b expected %b", obs_vec(), e);
    end
    tick();
    $display("reset mid-sweep: full sweep restarted");
  endtask

  task automatic test_random();
    logic [10:0] e;
    int g;
    int ra;
    for (int c = 0; c < 800; c++) begin
      flush_req = ($urandom_range(0, 59) == 0);
      @(negedge CLK);
      e = model_vec(g);
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL random_port[%0d]: got %b expected %b", c, obs_vec(), e);
      end
      ra = $urandom_range(0, 63);
      checks++;
      if (tb_ram[ra] !== m_mem[ra]) begin
        errors++;
        $display("FAIL random_ram[%0d] addr %0d: got %b expected %b",
                 c, ra, tb_ram[ra], m_mem[ra]);
      end
      if (g == 0) $display("txn %0d: req0 addr=%0d data=%0b", c, req0_addr, req0_data);
      if (g == 1) $display("txn %0d: req1 addr=%0d data=%0b", c, req1_addr, req1_data);
      tick();
      // A requester that was not granted keeps its request unchanged.
      if (!req0_valid || g == 0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_addr  = 6'($urandom_range(0, 63));
        req0_data  = 1'($urandom_range(0, 1));
      end
      if (!req1_valid || g == 1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_addr  = ($urandom_range(0, 3) == 0) ? req0_addr : 6'($urandom_range(0, 63));
        req1_data  = 1'($urandom_range(0, 1));
      end
    end
    req0_valid = 0; req1_valid = 0; flush_req = 0;
    tick();
    tick();
    @(negedge CLK);
    for (int a = 0; a < 64; a++) begin
      checks++;
      if (tb_ram[a] !== m_mem[a]) begin
        errors++;
        $display("FAIL final_ram addr %0d: got %b expected %b", a, tb_ram[a], m_mem[a]);
      end
    end
    tick();
  endtask

  initial begin
    RST_N = 0; flush_req = 0;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    m_run = 0; m_idx = 0; m_turn = 0;
    test_reset();
    test_init_sweep();
    test_alternate();
    test_single();
    test_collision();
    test_flush();
    test_reset_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
